// File: rtl/frog_hop_sequencer_if.sv
// Keycode-in / hop-out bundle between the keyboard source (master) and the
// frog hop sequencer (slave).
interface frog_hop_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      keycode;
  logic [15:0]      hop_keycode;
  logic             hop_active;
  logic             busy;
  logic [CNT_W-1:0] hop_count;

  modport master (
    output keycode,
    input  hop_keycode,
    input  hop_active,
    input  busy,
    input  hop_count
  );

  modport slave (
    input  keycode,
    output hop_keycode,
    output hop_active,
    output busy,
    output hop_count
  );
endinterface

// File: rtl/frog_hop_sequencer.sv
// Turns held keycodes into fixed-length hops with a post-hop cooldown.
// Optional one-deep press queue: define FROG_HOP_QUEUE_EN.
module frog_hop_sequencer #(
  parameter int HOP_FRAMES      = 8,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  frog_hop_sequencer_if.slave  hop_bus
);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  HOP  = 2'd1;
  localparam logic [1:0]  COOL = 2'd2;

  localparam logic [15:0] DIR_NONE  = 16'h0000;
  localparam logic [7:0]  HOP_LOAD  = 8'(HOP_FRAMES - 1);
  localparam logic [7:0]  COOL_LOAD = 8'(COOLDOWN_FRAMES - 1);
  localparam bit          HAS_COOL  = (COOLDOWN_FRAMES > 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Index order is UP, LEFT, DOWN, RIGHT; arrows fold onto the WASD code.
  localparam logic [15:0] WASD_CODES  [4] = '{16'h001A, 16'h0004, 16'h0016, 16'h0007};
  localparam logic [15:0] ARROW_CODES [4] = '{16'h0075, 16'h006B, 16'h0072, 16'h0074};

  logic [1:0]       state_reg, state_next;
  logic [7:0]       fcnt_reg, fcnt_next;
  logic [15:0]      hop_keycode_reg, hop_keycode_next;
  logic [CNT_W-1:0] hop_count_reg, hop_count_next;
  logic [15:0]      key_prev_reg;
  logic             pend_valid_reg;
  logic [15:0]      pend_dir_reg;

  logic [3:0]       hit;
  logic [15:0]      dir;
  logic             press;
  logic             start_hop;
  logic [15:0]      start_dir;
  logic             take_pending;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign hit[gi] = (hop_bus.keycode == WASD_CODES[gi]) ||
                       (hop_bus.keycode == ARROW_CODES[gi]);
    end
  endgenerate

  always_comb begin
    dir = DIR_NONE;
    for (int i = 0; i < 4; i++) begin
      if (hit[i]) begin
        dir = WASD_CODES[i];
      end
    end
  end

  assign press = (dir != DIR_NONE) && (dir != key_prev_reg);

  always_comb begin
    state_next       = state_reg;
    fcnt_next        = fcnt_reg;
    hop_keycode_next = hop_keycode_reg;
    hop_count_next   = hop_count_reg;
    start_hop        = 1'b0;
    start_dir        = DIR_NONE;
    take_pending     = 1'b0;

    case (state_reg)
      IDLE: begin
        // A pending slot can only be valid here if a press landed on the
        // edge that left HOP/COOL; a fresh press is newer and wins.
        take_pending = pend_valid_reg;
        if (press) begin
          start_hop = 1'b1;
          start_dir = dir;
        end else if (pend_valid_reg) begin
          start_hop = 1'b1;
          start_dir = pend_dir_reg;
        end
      end
      HOP: begin
        if (fcnt_reg != 8'd0) begin
          fcnt_next = fcnt_reg - 8'd1;
        end else begin
          hop_keycode_next = DIR_NONE;
          if (HAS_COOL) begin
            state_next = COOL;
            fcnt_next  = COOL_LOAD;
          end else if (pend_valid_reg) begin
            start_hop    = 1'b1;
            start_dir    = pend_dir_reg;
            take_pending = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      COOL: begin
        if (fcnt_reg != 8'd0) begin
          fcnt_next = fcnt_reg - 8'd1;
        end else if (pend_valid_reg) begin
          start_hop    = 1'b1;
          start_dir    = pend_dir_reg;
          take_pending = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next       = IDLE;
        fcnt_next        = 8'd0;
        hop_keycode_next = DIR_NONE;
      end
    endcase

    if (start_hop) begin
      state_next       = HOP;
      hop_keycode_next = start_dir;
      fcnt_next        = HOP_LOAD;
      hop_count_next   = hop_count_reg + CNT_ONE;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg       <= IDLE;
      fcnt_reg        <= 8'd0;
      hop_keycode_reg <= DIR_NONE;
      hop_count_reg   <= '0;
      key_prev_reg    <= DIR_NONE;
    end else begin
      state_reg       <= state_next;
      fcnt_reg        <= fcnt_next;
      hop_keycode_reg <= hop_keycode_next;
      hop_count_reg   <= hop_count_next;
      key_prev_reg    <= dir;
    end
  end

`ifdef FROG_HOP_QUEUE_EN
  logic        pend_valid_next;
  logic [15:0] pend_dir_next;

  // Capture runs after consumption, so a press on the edge a queued hop
  // starts becomes the new pending entry.
  always_comb begin
    pend_valid_next = pend_valid_reg && !take_pending;
    pend_dir_next   = pend_dir_reg;
    if (press && (state_reg != IDLE)) begin
      pend_valid_next = 1'b1;
      pend_dir_next   = dir;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pend_valid_reg <= 1'b0;
      pend_dir_reg   <= DIR_NONE;
    end else begin
      pend_valid_reg <= pend_valid_next;
      pend_dir_reg   <= pend_dir_next;
    end
  end
`else
  // Presses during HOP/COOL are dropped; key_prev still tracks them.
  logic unused_pending;
  assign pend_valid_reg = 1'b0;
  assign pend_dir_reg   = DIR_NONE;
  assign unused_pending = take_pending;
`endif

  assign hop_bus.hop_keycode = hop_keycode_reg;
  assign hop_bus.hop_active  = (state_reg == HOP);
  assign hop_bus.busy        = (state_reg != IDLE);
  assign hop_bus.hop_count   = hop_count_reg;

endmodule
